// File: rtl/fetch_pc_gen_pkg.sv
// Shared types and constants for the instruction-fetch PC generator.
// Redirect sources are ranked oldest-first: execute (jalr, branch) beats decode (jal).
package fetch_pc_gen_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INST_BYTES       = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DROP
  } state_e;

  // Higher encoding value means higher redirect priority.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_JAL  = 2'd1,
    SEL_BR   = 2'd2,
    SEL_JALR = 2'd3
  } redir_sel_e;

  function automatic redir_sel_e redir_select(input logic jalr,
                                              input logic br_taken,
                                              input logic jal);
    redir_sel_e sel;
    sel = SEL_NONE;
    if (jalr)          sel = SEL_JALR;
    else if (br_taken) sel = SEL_BR;
    else if (jal)      sel = SEL_JAL;
    return sel;
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Instruction-memory request/response bus plus the fetch-to-decode handshake.
// master = fetch_pc_gen; slave = memory and decode side.
interface fetch_pc_gen_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_inst,
    input  imem_ack, imem_rdata, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_inst,
    output imem_ack, imem_rdata, if_ready
  );

endinterface

// File: rtl/fetch_buf.sv
// One-entry valid/ready holding register between fetch and decode.
// Flush wins over load so a redirect never lets a wrong-path instruction through.
module fetch_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  // NOTE: non-blocking assignments keep every register reading pre-edge values, so block order never matters.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      // NOTE: the payload registers are reset as well so decode sees zeros, not X, straight out of reset.
      pc    <= 32'h0;
      inst  <= 32'h0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      inst  <= load_inst;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: owns the fetch PC, keeps one imem request outstanding,
// applies jalr/branch/jal redirects and discards the wrong-path response.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           jal,
  input  logic [31:0]    jpc,
  input  logic           jalr,
  input  logic [31:0]    jrpc,
  input  logic           br_taken,
  input  logic [31:0]    bpc,
  fetch_pc_gen_if.master bus,
  output logic           misalign
);

  state_e      state;
  logic [31:0] pc;
  logic [31:0] req_addr;

  redir_sel_e  sel;
  logic        redirect;
  logic [31:0] raw_target;
  logic [31:0] target;
  logic [31:0] pc_seq;
  logic        buf_load;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel        = redir_select(jalr, br_taken, jal);
    redirect   = (sel != SEL_NONE);
    raw_target = jpc;
    case (sel)
      SEL_JALR: raw_target = jrpc;
      SEL_BR:   raw_target = bpc;
      default:  raw_target = jpc;
    endcase
    target = {raw_target[31:2], 2'b00};
  end

  assign pc_seq = pc + INST_BYTES;

  // imem_addr only muxes registers; imem_req looks at if_ready and redirect but never at imem_ack.
  always_comb begin
    bus.imem_req  = 1'b0;
    bus.imem_addr = pc;
    case (state)
      IDLE: bus.imem_req = !rst && !redirect && (!bus.if_valid || bus.if_ready);
      BUSY, DROP: begin
        bus.imem_req  = !rst;
        bus.imem_addr = req_addr;
      end
      default: bus.imem_req = 1'b0;
    endcase
  end

  // A response is kept only for a right-path request; DROP data is always thrown away.
  assign buf_load = bus.imem_ack && !redirect &&
                    (((state == IDLE) && bus.imem_req) || (state == BUSY));

  fetch_buf u_fetch_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .flush     (redirect),
    .load_pc   (bus.imem_addr),
    .load_inst (bus.imem_rdata),
    .ready     (bus.if_ready),
    .valid     (bus.if_valid),
    .pc        (bus.if_pc),
    .inst      (bus.if_inst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      misalign <= redirect && (raw_target[1:0] != 2'b00);
      case (state)
        IDLE: begin
          if (redirect) begin
            pc <= target;
          end else if (bus.imem_req) begin
            req_addr <= pc;
            if (bus.imem_ack) pc    <= pc_seq;
            else              state <= BUSY;
          end
        end
        BUSY: begin
          if (bus.imem_ack) begin
            pc    <= redirect ? target : pc_seq;
            state <= IDLE;
          end else if (redirect) begin
            pc    <= target;
            state <= DROP;
          end
        end
        DROP: begin
          // pc already points at the redirect target; only the stale response remains.
          if (redirect)     pc    <= target;
          if (bus.imem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_addr_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.imem_req && !bus.imem_ack) |=> (bus.imem_req && $stable(bus.imem_addr)));

  a_no_overwrite: assert property (@(posedge clk) disable iff (rst)
    buf_load |-> (!bus.if_valid || bus.if_ready));

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios plus a randomized run checked
// against an instruction-stream model (sequential PCs restarted at each redirect).
module tb_fetch_pc_gen;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        jal;
  logic [31:0] jpc;
  logic        jalr;
  logic [31:0] jrpc;
  logic        br_taken;
  logic [31:0] bpc;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  fetch_pc_gen_if bus ();

  fetch_pc_gen #(.RESET_PC(RESET_PC)) dut (
    .clk      (clk),
    .rst      (rst),
    .jal      (jal),
    .jpc      (jpc),
    .jalr     (jalr),
    .jrpc     (jrpc),
    .br_taken (br_taken),
    .bpc      (bpc),
    .bus      (bus),
    .misalign (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Memory contents are a fixed function of the address; data is only meaningful with ack.
  assign bus.imem_rdata = bus.imem_ack ? inst_of(bus.imem_addr) : 32'hDEAD_BEEF;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    jal = 1'b0; jalr = 1'b0; br_taken = 1'b0;
    jpc = 32'h0; jrpc = 32'h0; bpc = 32'h0;
    bus.imem_ack = 1'b0;
    bus.if_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    jal = 1'b0; jalr = 1'b0; br_taken = 1'b0;
    jpc = 32'h0; jrpc = 32'h0; bpc = 32'h0;
    bus.imem_ack = 1'b1;
    bus.if_ready = 1'b1;
    step();
    step();
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got %h exp %h", bus.imem_addr, RESET_PC); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.if_valid); end
    checks++; if (bus.if_pc !== 32'h0 || bus.if_inst !== 32'h0) begin errors++; $display("FAIL reset_buf got %h/%h exp 0/0", bus.if_pc, bus.if_inst); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", misalign); end
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL first_req got %b@%h exp 1@%h", bus.imem_req, bus.imem_addr, RESET_PC); end
    step();
    #1;
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL no_ack_no_load got %b exp 0", bus.if_valid); end
  endtask

  task automatic test_stream();
    do_reset();
    bus.imem_ack = 1'b1;
    bus.if_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL stream_req[%0d] got %b@%h exp 1@%h", i, bus.imem_req, bus.imem_addr, 32'(4 * i)); end
      if (i == 0) begin
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL stream_valid0 got %b exp 0", bus.if_valid); end
      end else begin
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(4 * (i - 1)) || bus.if_inst !== inst_of(32'(4 * (i - 1)))) begin
          errors++; $display("FAIL stream_out[%0d] got v=%b pc=%h inst=%h exp v=1 pc=%h", i, bus.if_valid, bus.if_pc, bus.if_inst, 32'(4 * (i - 1)));
        end
      end
      step();
    end
  endtask

  task automatic test_wait();
    do_reset();
    bus.if_ready = 1'b1;
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin errors++; $display("FAIL wait_hold[%0d] got %b@%h exp 1@00000004", k, bus.imem_req, bus.imem_addr); end
      checks++; if (bus.if_valid !== (k == 0)) begin errors++; $display("FAIL wait_valid[%0d] got %b exp %b", k, bus.if_valid, (k == 0)); end
      step();
    end
    bus.imem_ack = 1'b1;
    #1;
    checks++; if (bus.imem_addr !== 32'h4 || bus.if_valid !== 1'b0) begin errors++; $display("FAIL wait_ack got %h v=%b exp 00000004 v=0", bus.imem_addr, bus.if_valid); end
    step();
    bus.imem_ack = 1'b0;
    #1;
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h4) begin errors++; $display("FAIL wait_out got v=%b pc=%h exp v=1 pc=00000004", bus.if_valid, bus.if_pc); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.if_ready = 1'b0;
    bus.imem_ack = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_req[%0d] got %b exp 0", k, bus.imem_req); end
      checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin errors++; $display("FAIL bp_hold[%0d] got v=%b pc=%h exp v=1 pc=0", k, bus.if_valid, bus.if_pc); end
      step();
    end
    bus.if_ready = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin errors++; $display("FAIL bp_release got %b@%h exp 1@00000004", bus.imem_req, bus.imem_addr); end
    step();
    #1;
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h4 || bus.if_inst !== inst_of(32'h4)) begin errors++; $display("FAIL bp_next got v=%b pc=%h exp v=1 pc=00000004", bus.if_valid, bus.if_pc); end
  endtask

  task automatic test_jal_busy();
    do_reset();
    bus.if_ready = 1'b1;
    bus.imem_ack = 1'b1;
    step();
    step();
    bus.imem_ack = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin errors++; $display("FAIL jb_issue got %b@%h exp 1@00000008", bus.imem_req, bus.imem_addr); end
    step();
    jal = 1'b1;
    jpc = 32'h100;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin errors++; $display("FAIL jb_busy got %b@%h exp 1@00000008", bus.imem_req, bus.imem_addr); end
    step();
    jal = 1'b0;
    bus.imem_ack = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin errors++; $display("FAIL jb_drop got %b@%h exp 1@00000008", bus.imem_req, bus.imem_addr); end
    step();
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin errors++; $display("FAIL jb_target got %b@%h exp 1@00000100", bus.imem_req, bus.imem_addr); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL jb_discard got v=%b pc=%h exp v=0", bus.if_valid, bus.if_pc); end
    step();
    bus.imem_ack = 1'b0;
    #1;
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100 || bus.if_inst !== inst_of(32'h100)) begin errors++; $display("FAIL jb_out got v=%b pc=%h exp v=1 pc=00000100", bus.if_valid, bus.if_pc); end
  endtask

  task automatic test_priority();
    do_reset();
    bus.if_ready = 1'b0;
    bus.imem_ack = 1'b1;
    step();
    jal = 1'b1;  jpc  = 32'h40;
    jalr = 1'b1; jrpc = 32'h200;
    bus.if_ready = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL pri_req_gate got %b exp 0", bus.imem_req); end
    step();
    jal = 1'b0; jalr = 1'b0;
    bus.if_ready = 1'b0;
    #1;
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL pri_flush got %b exp 0", bus.if_valid); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin errors++; $display("FAIL pri_jalr got %b@%h exp 1@00000200", bus.imem_req, bus.imem_addr); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL pri_aligned got %b exp 0", misalign); end
    step();
    br_taken = 1'b1;
    bpc = 32'h302;
    #1;
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h200) begin errors++; $display("FAIL pri_buf got v=%b pc=%h exp v=1 pc=00000200", bus.if_valid, bus.if_pc); end
    step();
    br_taken = 1'b0;
    bus.if_ready = 1'b1;
    #1;
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL br_misalign got %b exp 1", misalign); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300) begin errors++; $display("FAIL br_target got %b@%h exp 1@00000300", bus.imem_req, bus.imem_addr); end
    step();
    bus.imem_ack = 1'b0;
    #1;
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL br_pulse got %b exp 0", misalign); end
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h300) begin errors++; $display("FAIL br_out got v=%b pc=%h exp v=1 pc=00000300", bus.if_valid, bus.if_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.if_ready = 1'b1;
    bus.imem_ack = 1'b1;
    jal = 1'b1;
    jpc = 32'hFFFF_FFFC;
    step();
    jal = 1'b0;
    #1;
    checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got %h exp fffffffc", bus.imem_addr); end
    step();
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_zero got %b@%h exp 1@00000000", bus.imem_req, bus.imem_addr); end
    checks++; if (bus.if_pc !== 32'hFFFF_FFFC || bus.if_valid !== 1'b1) begin errors++; $display("FAIL wrap_out got v=%b pc=%h exp v=1 pc=fffffffc", bus.if_valid, bus.if_pc); end
  endtask

  task automatic test_reset_busy();
    do_reset();
    bus.if_ready = 1'b1;
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    step();
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin errors++; $display("FAIL rb_busy got %b@%h exp 1@00000004", bus.imem_req, bus.imem_addr); end
    rst = 1'b1;
    bus.imem_ack = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rb_req_in_rst got %b exp 0", bus.imem_req); end
    step();
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL rb_restart got %b@%h exp 1@%h", bus.imem_req, bus.imem_addr, RESET_PC); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rb_stale_ack got v=%b pc=%h exp v=0", bus.if_valid, bus.if_pc); end
    step();
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    #1;
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== RESET_PC || bus.if_inst !== inst_of(RESET_PC)) begin errors++; $display("FAIL rb_out got v=%b pc=%h exp v=1 pc=%h", bus.if_valid, bus.if_pc, RESET_PC); end
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  task automatic test_random();
    logic [31:0] exp_pc;
    logic        exp_mis;
    logic        mem_busy;
    logic [31:0] mem_addr;
    int unsigned mem_wait;
    int          deliveries;
    do_reset();
    exp_pc = RESET_PC; exp_mis = 1'b0;
    mem_busy = 1'b0; mem_addr = 32'h0; mem_wait = 0; deliveries = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.if_ready = ($urandom_range(0, 9) < 7);
      jal      = ($urandom_range(0, 31) == 0);
      jalr     = ($urandom_range(0, 31) == 0);
      br_taken = ($urandom_range(0, 31) == 0);
      jpc = rand_target(); jrpc = rand_target(); bpc = rand_target();
      bus.imem_ack = 1'b0;
      #1;
      if (mem_busy) begin
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== mem_addr) begin
          errors++; $display("FAIL rnd_hold cyc %0d got %b@%h exp 1@%h", cyc, bus.imem_req, bus.imem_addr, mem_addr);
          mem_busy = 1'b0;
        end
      end
      if (bus.imem_req === 1'b1) begin
        if (!mem_busy) begin
          mem_busy = 1'b1;
          mem_addr = bus.imem_addr;
          mem_wait = $urandom_range(0, 3);
        end
        if (mem_wait == 0) begin
          bus.imem_ack = 1'b1;
          mem_busy = 1'b0;
        end else begin
          mem_wait--;
        end
      end
      #1;
      checks++;
      if (misalign !== exp_mis) begin errors++; $display("FAIL rnd_misalign cyc %0d got %b exp %b", cyc, misalign, exp_mis); end
      if (bus.if_valid === 1'b1 && bus.if_ready === 1'b1) begin
        checks++;
        if (bus.if_pc !== exp_pc || bus.if_inst !== inst_of(exp_pc)) begin
          errors++; $display("FAIL rnd_stream cyc %0d got pc=%h inst=%h exp pc=%h inst=%h", cyc, bus.if_pc, bus.if_inst, exp_pc, inst_of(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end
      exp_mis = 1'b0;
      if (jalr) begin
        exp_pc = jrpc & ~32'd3; exp_mis = (jrpc[1:0] != 2'b00);
      end else if (br_taken) begin
        exp_pc = bpc & ~32'd3;  exp_mis = (bpc[1:0] != 2'b00);
      end else if (jal) begin
        exp_pc = jpc & ~32'd3;  exp_mis = (jpc[1:0] != 2'b00);
      end
      step();
    end
    jal = 1'b0; jalr = 1'b0; br_taken = 1'b0;
    checks++;
    if (deliveries < 200) begin errors++; $display("FAIL rnd_progress got %0d deliveries exp >= 200", deliveries); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_backpressure();
    test_jal_busy();
    test_priority();
    test_wrap();
    test_reset_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Instruction-fetch PC generator. It owns the architectural fetch PC, issues single-outstanding requests to instruction memory, and buffers one fetched instruction toward decode. It consumes the jump targets produced by the jump-address stage (jal/jpc, jalr/jrpc) and the branch target from execute, then redirects fetch and discards wrong-path instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- jal  in  1  decode-stage jal redirect request
- jpc  in  32  jal target
- jalr  in  1  execute-stage jalr redirect request
- jrpc  in  32  jalr target (bit0 already cleared)
- br_taken  in  1  execute-stage taken branch
- bpc  in  32  branch target
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address; stable while imem_req && !imem_ack
- imem_ack  in  1  response valid; may arrive same cycle as req or any later cycle
- imem_rdata  in  32  instruction; valid only when imem_ack
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts this cycle
- if_pc  out  32  PC of buffered instruction
- if_inst  out  32  buffered instruction
- misalign  out  1  one-cycle pulse: accepted redirect target had bits [1:0] != 0

## Operation
- Redirect priority: jalr > br_taken > jal (execute is older than decode). redirect = jalr | br_taken | jal; target = selected address with bits [1:0] forced to 0; misalign pulses the next cycle if the original bits [1:0] were nonzero.
- Any redirect clears the output buffer (if_valid <= 0) the same edge, even if if_ready is high.
- FSM states:
  - IDLE: no request outstanding. imem_req = !rst && (!if_valid || if_ready), addr = pc. On redirect: pc <= target, imem_req forced 0 this cycle. If req && ack, load the buffer and set pc <= pc+4, staying in IDLE. If req && !ack, go to BUSY.
  - BUSY: imem_req = 1, addr held. On ack without redirect, load the buffer, set pc <= pc+4, and go to IDLE. On ack with redirect, discard the data, set pc <= target, and go to IDLE. On redirect without ack, set pc <= target and go to DROP.
  - DROP: imem_req = 1, holding the old address (not pc). On ack, discard the data and go to IDLE. A further redirect updates pc to the new target (the latest wins).
- The old address is kept in a separate req_addr register, so pc may change during BUSY/DROP.
- Buffer load sets if_valid=1, if_pc=req address, and if_inst=imem_rdata. The buffer is empty or draining whenever a request issues, so an ack never finds it full.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0, misalign=0, pc=RESET_PC, state=IDLE.
- Reset mid-request abandons it. The memory side must tolerate the dropped request, and any ack during rst is ignored.
- First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.
- Zero-wait memory (ack same cycle) with if_ready=1 gives one instruction per cycle. if_valid rises the cycle after ack.
- Redirect in cycle t: the target is requested in cycle t+1 from IDLE, or the cycle after the pending ack from DROP.
- imem_req depends combinationally on if_ready and the redirect inputs. imem_addr is a register mux with no path from imem_ack.

## Structure
- Shared package entries:
  - state enum {IDLE, BUSY, DROP}
  - RESET_PC default
  - redirect-priority encoding constants
- One sub-module, fetch_buf: a one-entry valid/ready register with load and flush, owning if_valid/if_pc/if_inst.

## Test plan
- Reset, then if_ready=1 and ack tied high → imem_addr sequence 0,4,8,C. if_valid high from cycle 2 with matching if_pc.
- Ack delayed 3 cycles → imem_req and imem_addr=0x4 held 3 cycles. if_valid rises the cycle after ack.
- if_ready=0 with the buffer full → imem_req=0. Raising if_ready → the next request issues the same cycle.
- jal (jpc=0x100) while BUSY at 0x8 → 0x8 data discarded and never presented. The next request is 0x100. The buffer is flushed.
- jal (jpc=0x40) and jalr (jrpc=0x200) asserted the same cycle → the next fetch is 0x200. br_taken with bpc=0x302 → fetch 0x300 and misalign pulses 1 cycle.
- pc at 32'hFFFF_FFFC → the next fetch is 0x0. rst asserted while BUSY → the next post-reset request is RESET_PC and the stale ack is ignored.
